// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver for the test harness: deserialises the SoC TX line
// and buffers received bytes in a FIFO presented as a valid/ready stream.
module uart_rx_stream #(
    parameter int ClksPerBit = 16,
    parameter int FifoDepth  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rx_i,
    output logic [7:0]                   data_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         frame_err_o,
    output logic                         overflow_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   fifo_usage_o
);

    localparam int CW = $clog2(ClksPerBit);
    localparam int AW = $clog2(FifoDepth);
    localparam int UW = AW + 1;

    localparam logic [CW-1:0] CntHalf = CW'(ClksPerBit / 2 - 1);
    localparam logic [CW-1:0] CntFull = CW'(ClksPerBit - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    if (ClksPerBit < 4 || (ClksPerBit % 2) != 0) begin : g_bad_clks
        $error("ClksPerBit must be even and >= 4");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("FifoDepth must be a power of two and >= 2");
    end

    logic [1:0]    sync;
    logic          rx_s;
    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          push_req;
    logic          ferr;

    logic [7:0]    mem [FifoDepth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [UW-1:0] count;
    logic          pop;
    logic          push_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_i};
        end
    end

    assign rx_s = sync[1];

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        sh_n     = sh;
        push_req = 1'b0;
        ferr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_n   = CntHalf;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (!rx_s) begin
                    cnt_n   = CntFull;
                    idx_n   = 3'd0;
                    state_n = S_DATA;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    sh_n  = {rx_s, sh[7:1]};
                    cnt_n = CntFull;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    push_req = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    ferr    = 1'b1;
                    state_n = S_BREAK;
                end
            end
            S_BREAK: begin
                // Hold off start detection until the line goes idle again.
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            cnt         <= '0;
            idx         <= 3'd0;
            sh          <= 8'h00;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            state       <= state_n;
            busy_o      <= (state_n != S_IDLE);
            cnt         <= cnt_n;
            idx         <= idx_n;
            sh          <= sh_n;
            frame_err_o <= ferr;
            overflow_o  <= push_req && !push_ok;
        end
    end

    assign pop     = valid_o && ready_i;
    assign push_ok = push_req && ((count < UW'(FifoDepth)) || pop);

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= sh;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign valid_o      = (count != '0);
    assign data_o       = valid_o ? mem[rd_ptr] : 8'h00;
    assign fifo_usage_o = count;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: single byte latency, glitch,
// framing error, overflow, full-with-pop and mid-frame reset.
module tb_uart_rx_stream;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overflow;
    logic       busy;
    logic [4:0] usage;

    int vectors = 0;
    int errors  = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    logic [7:0] rxq[$];

    uart_rx_stream #(.ClksPerBit(C), .FifoDepth(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_err_o  (frame_err),
        .overflow_o   (overflow),
        .busy_o       (busy),
        .fifo_usage_o (usage)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
        if (valid && ready) rxq.push_back(data);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start bit plus eight data bits; leaves rx on the last data bit.
    task automatic send_head(input logic [7:0] b);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(C);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        rx = 1'b1;
        tick(C);
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        tick(3);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_usage", usage, 0);
        rst = 1'b0;
        tick(2);

        // single byte, 155-cycle latency
        ready = 1'b1;
        send_head(8'hA5);
        rx = 1'b1;
        tick(10);
        chk("lat_154_valid", valid, 0);
        chk("lat_154_busy", busy, 1);
        tick(1);
        chk("lat_155_valid", valid, 1);
        chk("lat_155_data", data, 8'hA5);
        chk("lat_155_usage", usage, 1);
        chk("lat_155_busy", busy, 0);
        tick(1);
        chk("lat_pop_valid", valid, 0);
        tick(C);
        chk("single_ferr", fe_cnt, 0);
        chk("single_ovf", ov_cnt, 0);
        chk("single_cnt", rxq.size(), 1);
        chk("single_byte", rxq[0], 8'hA5);
        rxq.delete();

        // start-bit glitch
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3);
        chk("glitch_busy_hi", busy, 1);
        tick(C);
        chk("glitch_busy_lo", busy, 0);
        chk("glitch_usage", usage, 0);
        chk("glitch_ferr", fe_cnt, 0);
        chk("glitch_ovf", ov_cnt, 0);
        chk("glitch_bytes", rxq.size(), 0);

        // framing error, then recovery
        send_head(8'h3C);
        rx = 1'b0;
        tick(2 * C);
        rx = 1'b1;
        tick(C);
        chk("ferr_pulses", fe_cnt, 1);
        chk("ferr_usage", usage, 0);
        chk("ferr_bytes", rxq.size(), 0);
        chk("ferr_busy", busy, 0);
        send_byte(8'h55);
        tick(2);
        chk("ferr_rec_cnt", rxq.size(), 1);
        chk("ferr_rec_byte", rxq[0], 8'h55);
        chk("ferr_pulses2", fe_cnt, 1);
        rxq.delete();

        // overflow
        ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        chk("ovf_full", usage, 16);
        chk("ovf_none", ov_cnt, 0);
        send_head(8'h10);
        rx = 1'b1;
        tick(11);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_usage", usage, 16);
        tick(1);
        chk("ovf_pulse_end", overflow, 0);
        tick(4);
        chk("ovf_count", ov_cnt, 1);
        ready = 1'b1;
        tick(20);
        chk("ovf_drain_usage", usage, 0);
        chk("ovf_drain_cnt", rxq.size(), 16);
        for (int i = 0; i < 16; i++) chk("ovf_order", rxq[i], 32'(i));
        rxq.delete();

        // full with simultaneous pop
        ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        send_head(8'h99);
        rx = 1'b1;
        tick(10);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("fp_ovf", overflow, 0);
        chk("fp_usage", usage, 16);
        tick(5);
        chk("fp_ov_cnt", ov_cnt, 1);
        ready = 1'b1;
        tick(20);
        chk("fp_drain_usage", usage, 0);
        chk("fp_drain_cnt", rxq.size(), 17);
        for (int i = 0; i < 16; i++) chk("fp_order", rxq[i], 32'(8'h20 + i));
        chk("fp_last", rxq[16], 8'h99);
        rxq.delete();

        // reset mid-frame
        ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("mr_usage3", usage, 3);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            tick(C);
        end
        rx = 1'b1;
        tick(8);
        chk("mr_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("mr_valid", valid, 0);
        chk("mr_data", data, 0);
        chk("mr_usage", usage, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ferr", frame_err, 0);
        chk("mr_ovf", overflow, 0);
        tick(2);
        rst = 1'b0;
        tick(5 * C);
        chk("mr_after_usage", usage, 0);
        chk("mr_after_valid", valid, 0);
        chk("mr_after_busy", busy, 0);
        ready = 1'b1;
        send_byte(8'h7E);
        tick(2);
        chk("mr_fresh_cnt", rxq.size(), 1);
        chk("mr_fresh_byte", rxq[0], 8'h7E);
        chk("mr_fe_total", fe_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Test-harness receiver that consumes the SoC UART transmit line, 8N1 format. Sits in parallel with the UART DPI model on the same wire.
- Deserialises each character, checks framing and buffers bytes in a FIFO.
- Presents the bytes as a valid/ready stream to a downstream console or scoreboard checker.
- Shares the SoC clock; the baud rate is expressed as clock cycles per bit.

Parameters:
- ClksPerBit, 16: clock cycles per UART bit. Must be even and >= 4; elaboration fails otherwise.
- FifoDepth, 16: byte FIFO entries. Must be a power of two and >= 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- rx_i  in  1  serial line; idles high
- data_o  out  8  head-of-FIFO byte
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overflow_o  out  1  one-cycle pulse: received byte dropped because the FIFO was full
- busy_o  out  1  FSM not in IDLE
- fifo_usage_o  out  $clog2(FifoDepth)+1  current FIFO occupancy

Behaviour:
- Reset values: all outputs 0, except data_o, which is 0 and don't-care while valid_o=0. The synchroniser flops reset to 1. FSM resets to IDLE. FIFO pointers and count reset to 0. Reset mid-frame discards the partial byte and all buffered bytes.
- Input: rx_i passes through a 2-flop synchroniser, giving rx_s. All sampling uses rx_s.
- Down-counter cnt: width $clog2(ClksPerBit). Bit index idx: 3 bits. Shift register sh: 8 bits, LSB first.
- FSM states and transitions:
  - IDLE: if rx_s==0, load cnt=ClksPerBit/2-1 and go to START.
  - START: decrement cnt. At cnt==0, sample rx_s. If 0: load cnt=ClksPerBit-1, idx=0, go to DATA. If 1 (glitch): go to IDLE, no flags raised.
  - DATA: decrement cnt. At cnt==0, shift rx_s into sh[7] (right shift) and reload cnt=ClksPerBit-1. If idx==7 go to STOP, else idx++.
  - STOP: decrement cnt. At cnt==0, sample rx_s. If 1: push sh, or pulse overflow_o if the push is rejected; go to IDLE. If 0: pulse frame_err_o, discard sh, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. No new start bit is detected until the line returns high.
- busy_o = (state != IDLE), registered together with the state.
- FIFO: registered count. valid_o = (count != 0); data_o = mem[rd_ptr]. Pointers wrap modulo FifoDepth.
- Push/pop rules:
  - Push is accepted if count < FifoDepth, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop with count==0 is ignored.
- Latency: a pushed byte appears with valid_o=1 on the cycle after the stop-bit sample. End to end, valid_o rises 2 + ClksPerBit/2 + 9*ClksPerBit + 1 cycles after the first clk_i edge that samples rx_i low. With the default ClksPerBit this is 155 cycles.
- Back-to-back characters: a start bit immediately following the stop-bit sample is detected from IDLE with no dead cycle beyond the synchroniser.
- data_o and valid_o stay stable while valid_o && !ready_i.

Test Plan:
- Single byte: ClksPerBit=16, drive 0xA5 in 8N1 with ready_i=1 -> valid_o pulses high exactly 155 cycles after rx_i falls, with data_o=0xA5. frame_err_o and overflow_o stay 0. busy_o returns to 0.
- Start-bit glitch: rx_i low for 3 cycles then high -> busy_o rises, then returns to 0 after the half-bit. No valid_o, frame_err_o or overflow_o.
- Framing error: send 0x3C with the stop bit held low for 2 bit times -> frame_err_o is a single 1-cycle pulse, fifo_usage_o stays 0. A following 0x55 sent after the line returns high is received correctly.
- Overflow: ready_i=0, send 17 bytes 0x00..0x10 -> fifo_usage_o=16 and overflow_o pulses once on byte 0x10. Then set ready_i=1 -> stream delivers 0x00..0x0F in order, and the count returns to 0.
- Full with simultaneous pop: FIFO full, ready_i=1 in the same cycle as the stop-bit push -> no overflow_o, fifo_usage_o stays 16, and the new byte is delivered last.
- Reset mid-frame: assert rst_i during bit 4 of a character with 3 bytes buffered -> all outputs are 0 the same cycle (asynchronous). After release, the remainder of the frame produces no byte, and a fresh 0x7E is received correctly.
